// File: rtl/pipeline_1_issue.sv
// Issue stage: holds one decoded instruction, blocks it on scoreboard hazards, hands it to execute.
// Optional ISSUE_STALL_CNT_EN adds a saturating hazard-stall cycle counter on stall_cycles.
module pipeline_1_issue #(
  parameter int CTRL_W = 22,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [2:0]        num_Rm_in,
  input  logic [2:0]        num_Rn_in,
  input  logic [2:0]        num_Rd_in,
  input  logic [2:0]        used_in,
  input  logic [5:0]        inst_type_in,
  input  logic [15:0]       sximm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [2:0]        num_Rm_out,
  output logic [2:0]        num_Rn_out,
  output logic [2:0]        num_Rd_out,
  output logic [5:0]        inst_type_out,
  output logic [15:0]       sximm_out,
  input  logic              wb_valid,
  input  logic [2:0]        wb_num,
  input  logic              flush,
  output logic [NREG-1:0]   pending_out
`ifdef ISSUE_STALL_CNT_EN
  , output logic [15:0]     stall_cycles
`endif
);

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never depends on ready.
  logic              hold_valid_q, hold_valid_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic [2:0]        num_rm_q, num_rm_d;
  logic [2:0]        num_rn_q, num_rn_d;
  logic [2:0]        num_rd_q, num_rd_d;
  logic [2:0]        used_q, used_d;
  logic [5:0]        inst_type_q, inst_type_d;
  logic [15:0]       sximm_q, sximm_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic [NREG-1:0]   wb_mask;
  logic [NREG-1:0]   busy;
  logic              wr_en;
  logic [2:0]        wr_num;
  logic              hazard;
  logic              issue;
  logic              accept;

  // A writeback in this cycle already satisfies any consumer waiting on that register.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_num] = 1'b1;
    busy   = pending_q & ~wb_mask;
    wr_en  = control_q[3];
    wr_num = control_q[2:0];
    hazard = (used_q[2] && busy[num_rm_q]) ||
             (used_q[1] && busy[num_rn_q]) ||
             (used_q[0] && busy[num_rd_q]) ||
             (wr_en && busy[wr_num]);
  end

  always_comb begin
    out_valid = !reset && hold_valid_q && !hazard && !flush;
    issue     = out_valid && out_ready;
    in_ready  = !reset && !flush && (!hold_valid_q || issue);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    control_d    = control_q;
    num_rm_d     = num_rm_q;
    num_rn_d     = num_rn_q;
    num_rd_d     = num_rd_q;
    used_d       = used_q;
    inst_type_d  = inst_type_q;
    sximm_d      = sximm_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      control_d    = control_in;
      num_rm_d     = num_Rm_in;
      num_rn_d     = num_Rn_in;
      num_rd_d     = num_Rd_in;
      used_d       = used_in;
      inst_type_d  = inst_type_in;
      sximm_d      = sximm_in;
    end else if (issue) begin
      hold_valid_d = 1'b0;
    end
    // Clear first, then set, so a same-register issue keeps the bit pending.
    pending_d = pending_q & ~wb_mask;
    if (issue && wr_en) pending_d[wr_num] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      control_q    <= '0;
      num_rm_q     <= '0;
      num_rn_q     <= '0;
      num_rd_q     <= '0;
      used_q       <= '0;
      inst_type_q  <= '0;
      sximm_q      <= '0;
      pending_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      control_q    <= control_d;
      num_rm_q     <= num_rm_d;
      num_rn_q     <= num_rn_d;
      num_rd_q     <= num_rd_d;
      used_q       <= used_d;
      inst_type_q  <= inst_type_d;
      sximm_q      <= sximm_d;
      pending_q    <= pending_d;
    end
  end

  assign control_out   = control_q;
  assign num_Rm_out    = num_rm_q;
  assign num_Rn_out    = num_rn_q;
  assign num_Rd_out    = num_rd_q;
  assign inst_type_out = inst_type_q;
  assign sximm_out     = sximm_q;
  assign pending_out   = pending_q;

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_valid_q && hazard && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_1_issue.sv
// Bench for pipeline_1_issue: directed scenarios plus random traffic against a behavioural model.
module tb_pipeline_1_issue;

  typedef struct packed {
    logic [21:0] ctrl;
    logic [2:0]  rm;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  used;
    logic [5:0]  it;
    logic [15:0] imm;
  } ins_t;

  // clock / reset / DUT signals
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [21:0] control_in;
  logic [2:0]  num_Rm_in, num_Rn_in, num_Rd_in, used_in;
  logic [5:0]  inst_type_in;
  logic [15:0] sximm_in;
  logic        out_valid, out_ready;
  logic [21:0] control_out;
  logic [2:0]  num_Rm_out, num_Rn_out, num_Rd_out;
  logic [5:0]  inst_type_out;
  logic [15:0] sximm_out;
  logic        wb_valid;
  logic [2:0]  wb_num;
  logic        flush;
  logic [7:0]  pending_out;
`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipeline_1_issue #(.CTRL_W(22), .NREG(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
    .num_Rd_in(num_Rd_in), .used_in(used_in), .inst_type_in(inst_type_in),
    .sximm_in(sximm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .control_out(control_out), .num_Rm_out(num_Rm_out), .num_Rn_out(num_Rn_out),
    .num_Rd_out(num_Rd_out), .inst_type_out(inst_type_out), .sximm_out(sximm_out),
    .wb_valid(wb_valid), .wb_num(wb_num), .flush(flush),
    .pending_out(pending_out)
`ifdef ISSUE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load(input ins_t i);
    control_in   = i.ctrl;
    num_Rm_in    = i.rm;
    num_Rn_in    = i.rn;
    num_Rd_in    = i.rd;
    used_in      = i.used;
    inst_type_in = i.it;
    sximm_in     = i.imm;
  endtask

  function automatic ins_t mk(input logic wr, input logic [2:0] wn, input logic [2:0] rm,
                              input logic [2:0] rn, input logic [2:0] rd, input logic [2:0] used,
                              input logic [15:0] imm);
    ins_t i;
    i.ctrl = {3'b101, 8'h40, 7'b0110100, wr, wn};
    i.rm = rm; i.rn = rn; i.rd = rd; i.used = used;
    i.it = 6'b000001; i.imm = imm;
    return i;
  endfunction

  // Behavioural model: one-slot holding buffer, per-register busy flags, stall tally.
  bit          m_ok = 0;
  bit          m_held;
  ins_t        m_shown;
  bit          m_pend[8];
  int unsigned m_stall;

  always @(negedge clk) begin
    bit   blocked, exp_ov, exp_ir, iss;
    logic [7:0] pend_vec;
    ins_t cur;
    int   regs[$];
    blocked = 0;
    if (m_held) begin
      regs = {};
      if (m_shown.used[2]) regs.push_back(m_shown.rm);
      if (m_shown.used[1]) regs.push_back(m_shown.rn);
      if (m_shown.used[0]) regs.push_back(m_shown.rd);
      if (m_shown.ctrl[3]) regs.push_back(m_shown.ctrl[2:0]);
      foreach (regs[k])
        if (m_pend[regs[k]] && !(wb_valid && wb_num == regs[k])) blocked = 1;
    end
    exp_ov = !reset && m_held && !blocked && !flush;
    iss    = exp_ov && out_ready;
    exp_ir = !reset && !flush && (!m_held || iss);
    if (reset) begin
      check("m_reset_ready", {31'd0, in_ready}, 32'd0);
      check("m_reset_valid", {31'd0, out_valid}, 32'd0);
    end else if (m_ok) begin
      for (int r = 0; r < 8; r++) pend_vec[r] = m_pend[r];
      check("m_in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      check("m_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      check("m_pending", {24'd0, pending_out}, {24'd0, pend_vec});
      check("m_ctrl", {10'd0, control_out}, {10'd0, m_shown.ctrl});
      check("m_regs", {23'd0, num_Rm_out, num_Rn_out, num_Rd_out},
            {23'd0, m_shown.rm, m_shown.rn, m_shown.rd});
      check("m_type_imm", {10'd0, inst_type_out, sximm_out}, {10'd0, m_shown.it, m_shown.imm});
`ifdef ISSUE_STALL_CNT_EN
      check("m_stall", {16'd0, stall_cycles}, m_stall);
`endif
    end
    // advance the model to the state after the coming rising edge
    if (reset) begin
      m_ok = 1; m_held = 0; m_shown = '0; m_stall = 0;
      for (int r = 0; r < 8; r++) m_pend[r] = 0;
    end else begin
      if (m_held && blocked && !flush && m_stall < 65535) m_stall++;
      if (wb_valid) m_pend[wb_num] = 0;
      if (iss && m_shown.ctrl[3]) m_pend[m_shown.ctrl[2:0]] = 1;
      cur = '{control_in, num_Rm_in, num_Rn_in, num_Rd_in, used_in, inst_type_in, sximm_in};
      if (flush) m_held = 0;
      else if (in_valid && exp_ir) begin m_held = 1; m_shown = cur; end
      else if (iss) m_held = 0;
    end
  end

  initial begin
    ins_t mov_r1, add_r2, mov_r3, x_ins, y_ins;
    mov_r1 = mk(1'b1, 3'd1, 3'd0, 3'd0, 3'd1, 3'b000, 16'd5);
    add_r2 = mk(1'b1, 3'd2, 3'd0, 3'd1, 3'd2, 3'b110, 16'd0);
    mov_r3 = mk(1'b1, 3'd3, 3'd0, 3'd0, 3'd3, 3'b000, 16'd7);
    x_ins  = '{22'h155550, 3'd4, 3'd5, 3'd6, 3'b000, 6'b000010, 16'hBEEF};
    y_ins  = '{22'h0AAA20, 3'd7, 3'd6, 3'd5, 3'b000, 6'b000100, 16'h1234};

    reset = 1; in_valid = 0; out_ready = 0; wb_valid = 0; wb_num = 0; flush = 0;
    load('0);
    nxt(); nxt();

    // MOV R1,#5 accepted at cycle 0, issues in cycle 1
    reset = 0; load(mov_r1); in_valid = 1; out_ready = 1;
    mid(); check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    nxt(); in_valid = 0;
    mid(); check("mov_valid", {31'd0, out_valid}, 32'd1);
    check("mov_ctrl", {10'd0, control_out}, {10'd0, mov_r1.ctrl});
    nxt();
    mid(); check("mov_pending", {24'd0, pending_out}, 32'h02);

    // RAW stall on R1, released by same-cycle writeback
    nxt(); load(add_r2); in_valid = 1;
    mid(); nxt(); in_valid = 0;
    repeat (3) begin
      mid();
      check("raw_stall_valid", {31'd0, out_valid}, 32'd0);
      check("raw_stall_ready", {31'd0, in_ready}, 32'd0);
      nxt();
    end
    wb_valid = 1; wb_num = 1;
    mid(); check("raw_bypass_valid", {31'd0, out_valid}, 32'd1);
    nxt(); wb_valid = 0;
    mid(); check("raw_pending", {24'd0, pending_out}, 32'h04);
`ifdef ISSUE_STALL_CNT_EN
    check("raw_stall_cnt", {16'd0, stall_cycles}, 32'd3);
`endif

    // issue and writeback of the same register: set wins
    nxt(); load(mov_r3); in_valid = 1;
    mid(); nxt(); in_valid = 0; wb_valid = 1; wb_num = 3;
    mid(); check("setclr_valid", {31'd0, out_valid}, 32'd1);
    nxt(); wb_valid = 0;
    mid(); check("setclr_pending", {24'd0, pending_out}, 32'h0C);

    // backpressure for three cycles, then issue with same-cycle accept
    nxt(); load(x_ins); in_valid = 1; out_ready = 0;
    mid(); nxt(); load(y_ins);
    repeat (3) begin
      mid();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      check("bp_ctrl", {10'd0, control_out}, {10'd0, x_ins.ctrl});
      nxt();
    end
    out_ready = 1;
    mid(); check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    nxt(); in_valid = 0;
    mid(); check("bp_next_ctrl", {10'd0, control_out}, {10'd0, y_ins.ctrl});
    check("bp_next_imm", {16'd0, sximm_out}, 32'h1234);

    // get pending to exactly R1, then hold a stalled ADD and flush it
    nxt(); wb_valid = 1; wb_num = 2;
    mid(); nxt(); wb_num = 3; load(mov_r1); in_valid = 1;
    mid(); nxt(); wb_valid = 0; load(add_r2);
    mid(); nxt(); in_valid = 0;
    mid(); check("flush_pre_pending", {24'd0, pending_out}, 32'h02);
    check("flush_pre_valid", {31'd0, out_valid}, 32'd0);
    nxt(); flush = 1; in_valid = 1; load(y_ins);
    mid(); check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd0);
    nxt(); flush = 0; in_valid = 0;
    mid(); check("flush_empty_ready", {31'd0, in_ready}, 32'd1);
    check("flush_empty_valid", {31'd0, out_valid}, 32'd0);
    check("flush_pending", {24'd0, pending_out}, 32'h02);

    // reset while a RAW-stalled instruction is held
    nxt(); load(add_r2); in_valid = 1;
    mid(); nxt(); in_valid = 0;
    mid(); check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    nxt(); reset = 1;
    mid(); check("rst_during_valid", {31'd0, out_valid}, 32'd0);
    nxt(); reset = 0;
    mid(); check("rst_pending", {24'd0, pending_out}, 32'h00);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ctrl", {10'd0, control_out}, 32'd0);
`ifdef ISSUE_STALL_CNT_EN
    check("rst_stall_cnt", {16'd0, stall_cycles}, 32'd0);
`endif

    // random traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      nxt();
      in_valid     = ($urandom_range(0, 3) != 0);
      control_in   = 22'($urandom);
      num_Rm_in    = 3'($urandom_range(0, 7));
      num_Rn_in    = 3'($urandom_range(0, 7));
      num_Rd_in    = 3'($urandom_range(0, 7));
      used_in      = 3'($urandom_range(0, 7));
      inst_type_in = 6'($urandom);
      sximm_in     = 16'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      wb_valid     = ($urandom_range(0, 4) < 2);
      wb_num       = 3'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 199) == 0);
    end
    nxt(); reset = 0; in_valid = 0; flush = 0; wb_valid = 0;
    mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
